fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch initiator that drives the instruction ROM's read port and buffers returned words for the decode stage. It walks a word-aligned program counter, issues one read address per cycle, and accepts a response only when the memory echoes the requested address. Accepted {pc, instr} pairs are queued in a small FIFO, and the decode stage drains that FIFO with a valid/ready handshake. A redirect from the branch or jump path flushes the FIFO and restarts fetch.

## Interface
- RESET_PC, 32'h0000_0000, fetch PC after reset; low 2 bits ignored.
- FIFO_DEPTH, 4, prefetch entries; power of two, at least 2.
- clk  in  1  sole clock; rising edge.
- rst  in  1  asynchronous, active-high reset.
- memAddr  out  32  read address to memory; equals fetchPc.
- memDin  in  32  read data.
- memAddrIn  in  32  address echoed with memDin.
- memReadValid  in  1  memDin/memAddrIn valid this cycle.
- memReady  in  1  memory able to serve.
- instr  out  32  FIFO head instruction.
- pc  out  32  FIFO head address.
- instrValid  out  1  FIFO non-empty.
- instrReady  in  1  decode consumes head when high with instrValid.
- redirect  in  1  flush and restart fetch.
- redirectPc  in  32  restart address.

## Operation
- Registers: fetchPc[31:0] with bits [1:0] always 0; FIFO storage; rd/wr pointers; count in 0..FIFO_DEPTH.
- pop = instrValid & instrReady.
- accept = memReady & memReadValid & (memAddrIn[31:2] == fetchPc[31:2]) & (count < FIFO_DEPTH | pop) & ~redirect.
- On accept: push {fetchPc, memDin}; fetchPc <= fetchPc + 4, with 32-bit wrap from 0xFFFF_FFFC to 0.
- Address mismatch (stale or foreign response): no push; fetchPc held.
- Full with no pop: no accept; memAddr held.
- Simultaneous push and pop at full is legal; count is unchanged.
- Redirect has priority over push and pop. On redirect: count <= 0, pointers <= 0, fetchPc <= {redirectPc[31:2], 2'b00}. Any response arriving in the redirect cycle is discarded.
- instr and pc are driven combinationally from the head entry. Storage resets to 0, so the head reads 0 when empty after reset.

## Timing
- Reset values: memAddr = RESET_PC & ~3; instr = 0; pc = 0; instrValid = 0; count = 0.
- Asserting rst mid-operation clears everything immediately, without waiting for a clock edge.
- Accept at edge N gives instrValid = 1 in cycle N+1.
- With a combinational memory and instrReady held high, throughput is one instruction per cycle.
- Redirect sampled at edge N:
  - instrValid = 0 and memAddr = new PC in cycle N+1.
  - First new instruction is valid in cycle N+2.
- memAddr changes only at clock edges and reset.
- Handshake: instr and pc hold stable while instrValid = 1 and instrReady = 0.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined:
  - A redirect with redirectPc[1:0] != 0 sets output misalignErr (1 bit, reset 0).
  - While misalignErr is set, accept is blocked.
  - The next aligned redirect clears misalignErr and restarts fetch normally.
- Undefined: the misalignErr port is absent and the low bits of redirectPc are silently cleared.

## Test plan
- Reset release, ROM model loaded with words 0–3 = B7000080, 83210000, 23a03000, 83a00000, instrReady = 1 -> successive cycles present pc/instr 0x0/B7000080, 0x4/83210000, 0x8/23a03000, 0xC/83a00000.
- instrReady = 0 for 10 cycles, FIFO_DEPTH = 4 -> FIFO holds pc 0x0–0xC, memAddr holds 0x10; then instrReady = 1 -> pops in order 0x0, 0x4, 0x8, 0xC, then 0x10.
- FIFO holding 3 entries, redirect with redirectPc = 0x8 -> next cycle instrValid = 0; following cycle pc = 0x8, instr = 23a03000; no old entries appear.
- Memory model returns memAddrIn = 0x4 while memAddr = 0x0, or memReady = 0 for 3 cycles -> no push and memAddr holds 0x0; normal flow resumes once the response is valid.
- rst pulsed while FIFO is half-full -> instrValid = 0 and memAddr = RESET_PC before the next edge.
- redirectPc = 0x6 -> with FETCH_MISALIGN_TRAP_EN, misalignErr = 1 and no fetch until redirect to 0x0; without it, fetch resumes at 0x4 (instr 83210000).

Source files
------------

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch initiator. It walks a word-aligned program counter,
// presents it to the instruction ROM as the read address, and accepts a
// returned word only when the memory echoes that address. Accepted
// {pc, instr} pairs go into a small prefetch FIFO. The decode stage drains
// the FIFO with a valid/ready handshake. A redirect flushes the FIFO and
// restarts fetch at the new address.
//
// Parameters
//   RESET_PC    fetch address after reset (low two bits ignored)
//   FIFO_DEPTH  prefetch entries, power of two, >= 2
//
// Ports
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   memAddr       read address to memory (the fetch PC)
//   memDin        read data from memory
//   memAddrIn     address echoed by memory alongside memDin
//   memReadValid  memDin/memAddrIn valid this cycle
//   memReady      memory able to serve
//   instr, pc     FIFO head entry (combinational from storage)
//   instrValid    FIFO non-empty
//   instrReady    decode consumes the head when high with instrValid
//   redirect      flush and restart fetch at redirectPc
//   redirectPc    restart address
//   misalignErr   (FETCH_MISALIGN_TRAP_EN only) sticky misaligned-redirect flag
//
// Build option
//   FETCH_MISALIGN_TRAP_EN  when defined, a redirect to a non-word-aligned
//                           address raises misalignErr and blocks fetch until
//                           the next aligned redirect. When undefined, the low
//                           bits of redirectPc are silently cleared.
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] memAddr,
    input  logic [31:0] memDin,
    input  logic [31:0] memAddrIn,
    input  logic        memReadValid,
    input  logic        memReady,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic        instrValid,
    input  logic        instrReady,
    input  logic        redirect,
    input  logic [31:0] redirectPc
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        misalignErr
`endif
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [31:0]      RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};
    localparam logic [CNT_W-1:0] DEPTH_CNT        = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ZERO         = CNT_W'(1'b0);
    localparam logic [CNT_W-1:0] CNT_ONE          = CNT_W'(1'b1);
    localparam logic [PTR_W-1:0] PTR_ZERO         = PTR_W'(1'b0);
    localparam logic [PTR_W-1:0] PTR_ONE          = PTR_W'(1'b1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
    logic [CNT_W-1:0] count_q,    count_d;
    logic [31:0]      pc_mem_q    [FIFO_DEPTH];
    logic [31:0]      pc_mem_d    [FIFO_DEPTH];
    logic [31:0]      instr_mem_q [FIFO_DEPTH];
    logic [31:0]      instr_mem_d [FIFO_DEPTH];

`ifdef FETCH_MISALIGN_TRAP_EN
    logic             misalign_q, misalign_d;
`endif

    // ------------------------------------------------------------------
    // Handshake / acceptance terms
    // ------------------------------------------------------------------
    logic not_empty_s;
    logic pop_s;
    logic addr_match_s;
    logic room_s;
    logic trap_block_s;
    logic accept_s;

    // Only the word part of the echo is compared; byte-offset bits are
    // meaningless for a word fetch.
    logic unused_s;
    assign unused_s = ^{memAddrIn[1:0], redirectPc[1:0]};

    // Decode handshake and response-acceptance qualification.
    always_comb begin
        not_empty_s  = (count_q != CNT_ZERO);
        pop_s        = not_empty_s & instrReady;
        addr_match_s = (memAddrIn[31:2] == fetch_pc_q[31:2]);
        // A pop in the same cycle frees a slot, so a full FIFO can still
        // take a new word while decode drains.
        room_s       = (count_q < DEPTH_CNT) | pop_s;
`ifdef FETCH_MISALIGN_TRAP_EN
        trap_block_s = misalign_q;
`else
        trap_block_s = 1'b0;
`endif
        // A response arriving alongside a redirect belongs to the old
        // stream and is dropped.
        accept_s     = memReady & memReadValid & addr_match_s & room_s &
                       ~redirect & ~trap_block_s;
    end

    // Next-state for PC, pointers, occupancy and the misalign flag.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
`ifdef FETCH_MISALIGN_TRAP_EN
        misalign_d = misalign_q;
`endif
        if (redirect) begin
            // Redirect outranks any push/pop in the same cycle.
            fetch_pc_d = {redirectPc[31:2], 2'b00};
            rd_ptr_d   = PTR_ZERO;
            wr_ptr_d   = PTR_ZERO;
            count_d    = CNT_ZERO;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_d = |redirectPc[1:0];
`endif
        end else begin
            if (accept_s) begin
                // 32-bit add wraps 0xFFFF_FFFC -> 0 naturally.
                fetch_pc_d = fetch_pc_q + 32'd4;
                wr_ptr_d   = wr_ptr_q + PTR_ONE;
            end else begin
                fetch_pc_d = fetch_pc_q;
                wr_ptr_d   = wr_ptr_q;
            end

            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end

            case ({accept_s, pop_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Next-state for FIFO storage: write the accepted pair at the tail.
    always_comb begin
        pc_mem_d    = pc_mem_q;
        instr_mem_d = instr_mem_q;
        if (accept_s) begin
            pc_mem_d[wr_ptr_q]    = fetch_pc_q;
            instr_mem_d[wr_ptr_q] = memDin;
        end else begin
            pc_mem_d    = pc_mem_q;
            instr_mem_d = instr_mem_q;
        end
    end

    // Control-state register with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC_ALIGNED;
            rd_ptr_q   <= PTR_ZERO;
            wr_ptr_q   <= PTR_ZERO;
            count_q    <= CNT_ZERO;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // FIFO storage register; cleared on reset so an empty head reads zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_mem_q    <= '{default: 32'h0000_0000};
            instr_mem_q <= '{default: 32'h0000_0000};
        end else begin
            pc_mem_q    <= pc_mem_d;
            instr_mem_q <= instr_mem_d;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    // Sticky misaligned-redirect flag; only a redirect changes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign misalignErr = misalign_q;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign memAddr    = fetch_pc_q;
    assign instr      = instr_mem_q[rd_ptr_q];
    assign pc         = pc_mem_q[rd_ptr_q];
    assign instrValid = not_empty_s;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam int          FIFO_DEPTH = 4;

    logic        clk;
    logic        rst;
    logic [31:0] memAddr;
    logic [31:0] memDin;
    logic [31:0] memAddrIn;
    logic        memReadValid;
    logic        memReady;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        instrValid;
    logic        instrReady;
    logic        redirect;
    logic [31:0] redirectPc;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misalignErr;
`endif

    // Memory model knobs
    logic        corrupt;
    logic [31:0] rom [64];

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    // Behavioural reference
    ent_t        q[$];
    logic [31:0] model_pc;
    bit          model_err;

    fetch_unit #(
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .memAddr      (memAddr),
        .memDin       (memDin),
        .memAddrIn    (memAddrIn),
        .memReadValid (memReadValid),
        .memReady     (memReady),
        .instr        (instr),
        .pc           (pc),
        .instrValid   (instrValid),
        .instrReady   (instrReady),
        .redirect     (redirect),
        .redirectPc   (redirectPc)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .misalignErr  (misalignErr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational ROM: echoes the requested address, or a wrong one when corrupt.
    assign memAddrIn = corrupt ? (memAddr + 32'd4) : memAddr;
    assign memDin    = rom[memAddrIn[7:2]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        model_pc  = RESET_PC & ~32'd3;
        model_err = 1'b0;
    endtask

    task automatic compare_model();
        chk("memAddr", memAddr, model_pc);
        chk("instrValid", {31'd0, instrValid}, {31'd0, q.size() != 0});
        if (q.size() != 0) begin
            chk("pc", pc, q[0].pc);
            chk("instr", instr, q[0].ins);
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("misalignErr", {31'd0, misalignErr}, {31'd0, model_err});
`endif
    endtask

    // One clock: evaluate the rules on the settled inputs, advance at the
    // rising edge, then check everything on the falling edge.
    task automatic tick();
        bit          do_pop, do_acc, do_redir, n_err;
        logic [31:0] n_pc;
        ent_t        e;
        #1;
        do_redir = redirect;
        do_pop   = (q.size() != 0) && instrReady;
        do_acc   = memReady && memReadValid &&
                   (memAddrIn[31:2] == model_pc[31:2]) &&
                   ((q.size() < FIFO_DEPTH) || do_pop) && !model_err && !redirect;
        e.pc  = model_pc;
        e.ins = memDin;
        n_pc  = {redirectPc[31:2], 2'b00};
`ifdef FETCH_MISALIGN_TRAP_EN
        n_err = (redirectPc[1:0] != 2'b00);
`else
        n_err = 1'b0;
`endif
        @(posedge clk);
        if (do_redir) begin
            q.delete();
            model_pc  = n_pc;
            model_err = n_err;
        end else begin
            if (do_pop) void'(q.pop_front());
            if (do_acc) begin
                q.push_back(e);
                model_pc = model_pc + 32'd4;
            end
        end
        @(negedge clk);
        compare_model();
    endtask

    task automatic set_idle();
        memReady     = 1'b1;
        memReadValid = 1'b1;
        corrupt      = 1'b0;
        instrReady   = 1'b1;
        redirect     = 1'b0;
        redirectPc   = 32'h0;
    endtask

    // Asynchronous reset pulse between edges; outputs must clear before the next edge.
    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("rst_instrValid", {31'd0, instrValid}, 32'd0);
        chk("rst_memAddr", memAddr, RESET_PC & ~32'd3);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc", pc, 32'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rom[0] = 32'hB700_0080;
        rom[1] = 32'h8321_0000;
        rom[2] = 32'h23a0_3000;
        rom[3] = 32'h83a0_0000;
        for (int i = 4; i < 64; i++) rom[i] = $urandom;

        rst = 1'b1;
        set_idle();
        memReadValid = 1'b0;
        model_reset();
        @(negedge clk);
        chk("reset_memAddr", memAddr, 32'h0);
        chk("reset_instrValid", {31'd0, instrValid}, 32'd0);
        chk("reset_instr", instr, 32'h0);
        chk("reset_pc", pc, 32'h0);
        rst = 1'b0;

        // Streaming at one instruction per cycle
        set_idle();
        tick(); chk("s0_pc", pc, 32'h0); chk("s0_instr", instr, 32'hB700_0080);
        tick(); chk("s1_pc", pc, 32'h4); chk("s1_instr", instr, 32'h8321_0000);
        tick(); chk("s2_pc", pc, 32'h8); chk("s2_instr", instr, 32'h23a0_3000);
        tick(); chk("s3_pc", pc, 32'hC); chk("s3_instr", instr, 32'h83a0_0000);

        // Back-pressure fills the FIFO, then drains in order
        do_reset();
        set_idle();
        instrReady = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("full_memAddr", memAddr, 32'h10);
        chk("full_head", pc, 32'h0);
        instrReady = 1'b1;
        tick(); chk("drain1", pc, 32'h4);
        tick(); chk("drain2", pc, 32'h8);
        tick(); chk("drain3", pc, 32'hC);
        tick(); chk("drain4", pc, 32'h10);

        // Redirect flushes three buffered entries
        do_reset();
        set_idle();
        instrReady = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        redirect   = 1'b1;
        redirectPc = 32'h8;
        tick();
        chk("redir_valid", {31'd0, instrValid}, 32'd0);
        chk("redir_memAddr", memAddr, 32'h8);
        redirect = 1'b0;
        tick();
        chk("redir_pc", pc, 32'h8);
        chk("redir_instr", instr, 32'h23a0_3000);

        // Wrong echo and memory not ready hold the fetch address
        do_reset();
        set_idle();
        corrupt = 1'b1;
        tick(); tick();
        chk("mism_memAddr", memAddr, 32'h0);
        chk("mism_valid", {31'd0, instrValid}, 32'd0);
        corrupt  = 1'b0;
        memReady = 1'b0;
        tick(); tick(); tick();
        chk("nrdy_memAddr", memAddr, 32'h0);
        memReady = 1'b1;
        tick();
        chk("resume_pc", pc, 32'h0);
        chk("resume_instr", instr, 32'hB700_0080);

        // Reset while half full
        instrReady = 1'b0;
        tick();
        do_reset();

        // Misaligned redirect
        set_idle();
        redirect   = 1'b1;
        redirectPc = 32'h6;
        tick();
        redirect = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("mis_err", {31'd0, misalignErr}, 32'd1);
        tick(); tick(); tick();
        chk("mis_blocked", {31'd0, instrValid}, 32'd0);
        redirect   = 1'b1;
        redirectPc = 32'h0;
        tick();
        redirect = 1'b0;
        chk("mis_clear", {31'd0, misalignErr}, 32'd0);
        tick();
        chk("mis_pc", pc, 32'h0);
        chk("mis_instr", instr, 32'hB700_0080);
`else
        chk("mis_memAddr", memAddr, 32'h4);
        tick();
        chk("mis_pc", pc, 32'h4);
        chk("mis_instr", instr, 32'h8321_0000);
`endif

        // Address wrap at the top of the space
        set_idle();
        redirect   = 1'b1;
        redirectPc = 32'hFFFF_FFF8;
        tick();
        redirect = 1'b0;
        tick(); tick();
        chk("wrap_memAddr", memAddr, 32'h0);
        chk("wrap_pc", pc, 32'hFFFF_FFFC);

        // Randomized traffic against the reference
        for (int n = 0; n < 3000; n++) begin
            memReady     = ($urandom_range(0, 99) < 85);
            memReadValid = ($urandom_range(0, 99) < 85);
            corrupt      = ($urandom_range(0, 99) < 10);
            instrReady   = ($urandom_range(0, 99) < 65);
            redirect     = ($urandom_range(0, 99) < 5);
            redirectPc   = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) redirectPc = redirectPc | 32'hFFFF_FF00;
            if ($urandom_range(0, 9) != 0) redirectPc[1:0] = 2'b00;
            tick();
            if ($urandom_range(0, 499) == 0) begin
                set_idle();
                do_reset();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
